debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/sync_chain.sv | 43 ++++
 rtl/debounce_sync.sv | 133 +++++++++++++
 tb/tb_debounce_sync.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : debounce_pkg                                           |
// | Description : Shared types and default constants for debounce_sync.  |
// |               Holds the debounce FSM state enum and the default      |
// |               values of the SYNC_STAGES, DEBOUNCE_CYCLES and CNT_W   |
// |               parameters.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package debounce_pkg;

    localparam int c_sync_stages_default     = 2;
    localparam int c_debounce_cycles_default = 4;
    localparam int c_cnt_w_default           = 8;

    // STABLE_* : level accepted; WAIT_* : candidate new level being qualified
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_chain                                             |
// | Description : Multi-flop synchronizer bringing an asynchronous level |
// |               into the CLK domain.                                   |
// | Ports       : CLK - clock, rising edge                               |
// |               RST - asynchronous active-high reset, clears all flops |
// |               D   - asynchronous input level                         |
// |               Q   - synchronized level (last flop of the chain)      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = c_sync_stages_default
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("sync_chain: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    // Bit 0 is the metastability-exposed flop; the top bit is the output
    logic [SYNC_STAGES-1:0] r_stage;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], D};
        end
    end

    assign Q = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : debounce_sync                                          |
// | Description : Synchronizes a raw asynchronous level (switch/button)  |
// |               and accepts a new level only after it has been stable  |
// |               for DEBOUNCE_CYCLES further synchronized samples.      |
// |               Emits one-cycle RISE/FALL pulses on accepted changes.  |
// | Ports       : CLK  - clock, rising edge                              |
// |               RST  - asynchronous active-high reset                  |
// |               D    - raw asynchronous input level                    |
// |               Q    - debounced registered level                      |
// |               Qn   - inverse of Q                                    |
// |               RISE - one-cycle pulse in the first cycle Q is 1       |
// |               FALL - one-cycle pulse in the first cycle Q is 0       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = c_sync_stages_default,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default,
    parameter int CNT_W           = c_cnt_w_default
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q,
    output logic Qn,
    output logic RISE,
    output logic FALL
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("debounce_sync: SYNC_STAGES must be in 2..4");
        end
        if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
            $error("debounce_sync: CNT_W must be in 1..31");
        end
        if (DEBOUNCE_CYCLES < 1 ||
            longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_debounce_cycles
            $error("debounce_sync: DEBOUNCE_CYCLES must be in 1..2**CNT_W-1");
        end
    endgenerate

    // Terminal count: the transition happens on the sample that finds cnt here,
    // so cnt never exceeds this value and never wraps.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_d_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .CLK (CLK),
        .RST (RST),
        .D   (D),
        .Q   (w_d_sync)
    );

    // Q, RISE and FALL are loaded together with the state change so they are
    // registered and line up exactly with the accepted transition.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_d_sync) begin
                        r_state <= WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!w_d_sync) begin
                        // glitch rejected: fall back silently
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_q     <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_d_sync) begin
                        r_state <= WAIT_LO;
                        r_cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (w_d_sync) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_q     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign Qn   = ~r_q;
    assign RISE = r_rise;
    assign FALL = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_debounce_sync                                       |
// | Description : Self-checking bench for debounce_sync: directed        |
// |               scenarios with fixed latency expectations plus a       |
// |               randomized run compared against a reference model.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 8;
    localparam int LAT             = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d   = 1'b0;
    logic q, qn, rise, fall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .D    (d),
        .Q    (q),
        .Qn   (qn),
        .RISE (rise),
        .FALL (fall)
    );

    // Reference model: the synchronizer is a plain delay line of D samples;
    // a new level is accepted once the last DEBOUNCE_CYCLES+1 synchronized
    // samples all differ from the current output level.
    logic dq[$];
    logic hist[$];
    logic rd;
    logic all_diff;
    logic m_q    = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dq.delete();
            hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) dq.push_back(1'b0);
            m_q    = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            rd = dq.pop_front();
            dq.push_back(d);
            hist.push_back(rd);
            if (hist.size() > DEBOUNCE_CYCLES + 1) void'(hist.pop_front());
            all_diff = (hist.size() == DEBOUNCE_CYCLES + 1);
            foreach (hist[i]) if (hist[i] == m_q) all_diff = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (all_diff) begin
                m_rise = !m_q;
                m_fall = m_q;
                m_q    = !m_q;
            end
        end
    end

    // Drive D mid-low-phase, let one rising edge pass, return 2 ns after the
    // following falling edge where outputs are stable.
    task automatic step(input logic dval);
        d = dval;
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic settle(input logic lvl);
        for (int i = 0; i < LAT + 4; i++) step(lvl);
    endtask

    task automatic test_reset();
        int rises = 0;
        logic exp_q, exp_rise;
        d = 1'b1;
        rst = 1'b1;
        n_checks++;
        if (q !== 1'b0 || qn !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: Q=%b Qn=%b RISE=%b FALL=%b, required Q=0 Qn=1 RISE=0 FALL=0", q, qn, rise, fall);
        end
        step(1'b1);
        n_checks++;
        if (q !== 1'b0 || qn !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: Q=%b Qn=%b RISE=%b FALL=%b, required Q=0 Qn=1 RISE=0 FALL=0", q, qn, rise, fall);
        end
        rst = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step(1'b1);
            rises += int'(rise);
            exp_q    = (k >= LAT);
            exp_rise = (k == LAT);
            n_checks++;
            if (q !== exp_q || qn !== !exp_q || rise !== exp_rise || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: Q=%b Qn=%b RISE=%b FALL=%b, required Q=%b Qn=%b RISE=%b FALL=0",
                         k, q, qn, rise, fall, exp_q, !exp_q, exp_rise);
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL reset_release_rise_count: got %0d, required 1", rises);
        end
    endtask

    task automatic test_clean_fall();
        int falls = 0;
        logic exp_q, exp_fall;
        settle(1'b1);
        for (int k = 1; k <= LAT + 3; k++) begin
            step(1'b0);
            falls += int'(fall);
            exp_q    = (k < LAT);
            exp_fall = (k == LAT);
            n_checks++;
            if (q !== exp_q || qn !== !exp_q || fall !== exp_fall || rise !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_fall edge %0d: Q=%b Qn=%b RISE=%b FALL=%b, required Q=%b Qn=%b RISE=0 FALL=%b",
                         k, q, qn, rise, fall, exp_q, !exp_q, exp_fall);
            end
        end
        n_checks++;
        if (falls != 1) begin
            n_fail++;
            $display("FAIL clean_fall_count: got %0d, required 1", falls);
        end
    endtask

    task automatic test_glitch();
        settle(1'b0);
        // five 20 ns high pulses separated by 30 ns low
        for (int i = 0; i < 25 + LAT; i++) begin
            step((i < 25) && ((i % 5) < 2));
            n_checks++;
            if (q !== 1'b0 || qn !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch step %0d: Q=%b Qn=%b RISE=%b FALL=%b, required Q=0 Qn=1 RISE=0 FALL=0",
                         i, q, qn, rise, fall);
            end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        logic exp_q, exp_rise;
        settle(1'b0);
        for (int i = 0; i < 6; i++) begin
            step((i % 2) == 0);
            rises += int'(rise);
            n_checks++;
            if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_toggle step %0d: Q=%b RISE=%b FALL=%b, required Q=0 RISE=0 FALL=0",
                         i, q, rise, fall);
            end
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            step(1'b1);
            rises += int'(rise);
            exp_q    = (k >= LAT);
            exp_rise = (k == LAT);
            n_checks++;
            if (q !== exp_q || rise !== exp_rise || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_hold edge %0d: Q=%b RISE=%b FALL=%b, required Q=%b RISE=%b FALL=0",
                         k, q, rise, fall, exp_q, exp_rise);
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d, required 1", rises);
        end
    endtask

    task automatic test_clean_rise();
        int rises = 0;
        logic exp_q, exp_rise;
        settle(1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            rises += int'(rise);
            exp_q    = (k >= LAT);
            exp_rise = (k == LAT);
            n_checks++;
            if (q !== exp_q || qn !== !exp_q || rise !== exp_rise || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_rise edge %0d: Q=%b Qn=%b RISE=%b FALL=%b, required Q=%b Qn=%b RISE=%b FALL=0",
                         k, q, qn, rise, fall, exp_q, !exp_q, exp_rise);
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL clean_rise_count: got %0d, required 1", rises);
        end
    endtask

    task automatic test_reset_mid_wait();
        int rises = 0;
        logic exp_q, exp_rise;
        settle(1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1);
            rises += int'(rise);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || dut.r_state !== STABLE_LO) begin
            n_fail++;
            $display("FAIL reset_mid_wait_abort: Q=%b RISE=%b FALL=%b state=%0d, required Q=0 RISE=0 FALL=0 state=%0d",
                     q, rise, fall, dut.r_state, STABLE_LO);
        end
        step(1'b1);
        rst = 1'b0;
        n_checks++;
        if (rises != 0 || q !== 1'b0 || rise !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait_no_pulse: rises=%0d Q=%b RISE=%b, required rises=0 Q=0 RISE=0", rises, q, rise);
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            step(1'b1);
            rises += int'(rise);
            exp_q    = (k >= LAT);
            exp_rise = (k == LAT);
            n_checks++;
            if (q !== exp_q || rise !== exp_rise || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_wait_release edge %0d: Q=%b RISE=%b FALL=%b, required Q=%b RISE=%b FALL=0",
                         k, q, rise, fall, exp_q, exp_rise);
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL reset_mid_wait_rise_count: got %0d, required 1", rises);
        end
    endtask

    task automatic test_random();
        int   run_left = 0;
        logic lvl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (run_left == 0) begin
                lvl      = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 2 * DEBOUNCE_CYCLES + 2));
            end
            run_left--;
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            step(lvl);
            rst = 1'b0;
            n_checks++;
            if (q !== m_q || qn !== !m_q || rise !== m_rise || fall !== m_fall) begin
                n_fail++;
                $display("FAIL random cycle %0d: Q=%b Qn=%b RISE=%b FALL=%b, required Q=%b Qn=%b RISE=%b FALL=%b",
                         i, q, qn, rise, fall, m_q, !m_q, m_rise, m_fall);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        #2;
        test_reset();
        test_clean_fall();
        test_glitch();
        test_bounce();
        test_clean_rise();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
